comparador_serial_der_izq: RTL and testbench
============================================

Name: comparador_serial_der_izq

Overview:
- Clocked, bit-serial magnitude comparator for two unsigned N-bit words A and B.
- Consumes one (Ai, Bi) pair per accepted cycle, least-significant bit first (right to left).
- It is the sequential counterpart of the combinational left-to-right iterative network and uses the same state encoding.
- Sits after any serializer that emits LSB-first pairs; reports the A/B relation once all N bits are consumed.

Parameters:
- N, 8, word width in bits (N >= 2).
- CW, $clog2(N), bit-counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begins a new comparison; honoured only in IDLE.
- bit_valid  input  1  Ai/Bi carry a valid bit pair this cycle.
- Ai  input  1  current bit of A.
- Bi  input  1  current bit of B.
- busy  output  1  high in RECIBE.
- done  output  1  one-cycle pulse in FIN.
- resultado  output  2  00 = no result, 01 = A==B, 10 = A>B, 11 = A<B.
- bit_count  output  CW  number of pairs accepted in the current word.
- abort  input  1  present only with COMPARADOR_ABORT_EN.

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n); reset sampled only on the rising edge of clk.
- Reset values: FSM = IDLE, busy = 0, done = 0, resultado = 00, bit_count = 0, internal relation register = 01.
- FSM states: IDLE, RECIBE, FIN.
- IDLE:
  - start = 1: go to RECIBE, clear bit_count, set relation = 01.
  - bit_valid is ignored in IDLE.
  - resultado keeps its last value.
- RECIBE: on each cycle with bit_valid = 1:
  - Ai == Bi: relation unchanged.
  - Ai = 1, Bi = 0: relation = 10.
  - Ai = 0, Bi = 1: relation = 11.
  - bit_count increments by 1.
  - A higher-order differing bit always overrides the relation from lower bits.
  - Cycles with bit_valid = 0 are stalls: nothing changes.
  - start is ignored while in RECIBE.
- Nth accepted pair (bit_count == N-1 and bit_valid = 1):
  - The relation update for that pair is included.
  - Go to FIN; the relation is latched into resultado on the same edge.
- FIN (exactly one cycle):
  - done = 1, busy = 0; resultado is valid.
  - Unconditionally return to IDLE; start in FIN is ignored.
- Latency: done is high in the cycle immediately after the edge that accepted the Nth pair. The minimum word time is 1 (start) + N + 1 cycles.
- resultado holds until the FIN of the next comparison. An in-progress word never disturbs resultado.
- bit_count never wraps within a word; it is cleared only by start or reset.
- Reset mid-operation: rst_n = 0 on any edge forces the full reset state. No done is produced and resultado returns to 00.

Optional Feature:
- Macro: COMPARADOR_ABORT_EN.
- Defined:
  - Adds the abort input.
  - abort = 1 in RECIBE: next edge goes to IDLE, no done pulse, resultado unchanged, bit_count cleared.
  - abort has priority over bit_valid on the same edge.
  - abort is ignored in IDLE and FIN.
- Undefined:
  - No abort port.
  - A started word must run to completion or be cleared by reset.

Decomposition:
- Shared package/include (comparador_defs): relation codes REL_NONE = 00, REL_IGUAL = 01, REL_MAYOR = 10, REL_MENOR = 11; FSM state codes. The left-to-right network uses the same package.
- Sub-module celda_der_izq: combinational next-relation cell with inputs (relation[1:0], Ai, Bi) and output next relation. Instantiated once and fed back through the relation register.

Test Plan:
- Reset check: hold rst_n = 0 for 2 edges, then release -> busy = 0, done = 0, resultado = 00, bit_count = 0.
- N = 4, A = 1010, B = 0110, LSB-first pairs (0,0), (1,1), (0,1), (1,0) on consecutive cycles -> busy for 4 cycles, done pulse 1 cycle after the 4th pair, resultado = 10.
- N = 4, A = B = 0101 with bit_valid low for 2 cycles between pairs 2 and 3 -> bit_count holds during the stall, resultado = 01, done exactly once.
- N = 4, A = 0011, B = 1000 (bit0 favours A, bit3 favours B) -> resultado = 11. Also pulse start mid-word -> ignored, no restart.
- Drop rst_n after 2 pairs of a word -> FSM in IDLE next cycle, resultado = 00, no done pulse.
- With COMPARADOR_ABORT_EN: assert abort together with bit_valid after pair 3 of a word following a completed result 10 -> IDLE, no done, resultado stays 10, bit_count = 0.

Source files
------------

// File: rtl/comparador_serial_der_izq_pkg.sv
// Shared definitions for the right-to-left serial comparator and its left-to-right sibling.
// Provides the relation codes and the FSM state encoding.
package comparador_defs;

  localparam logic [1:0] REL_NONE  = 2'b00;
  localparam logic [1:0] REL_IGUAL = 2'b01;
  localparam logic [1:0] REL_MAYOR = 2'b10;
  localparam logic [1:0] REL_MENOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RECIBE = 2'b01,
    FIN    = 2'b10
  } estado_t;

endpackage

// File: rtl/comparador_serial_der_izq_celda.sv
// Combinational next-relation cell: a differing bit pair overrides whatever the
// lower-order bits decided, an equal pair passes the incoming relation through.
module celda_der_izq
  import comparador_defs::*;
(
  input  logic [1:0] relation,
  input  logic       Ai,
  input  logic       Bi,
  output logic [1:0] next_relation
);

  always_comb begin
    next_relation = relation;
    if (Ai && !Bi) begin
      next_relation = REL_MAYOR;
    end else if (!Ai && Bi) begin
      next_relation = REL_MENOR;
    end
  end

endmodule

// File: rtl/comparador_serial_der_izq.sv
// Bit-serial LSB-first magnitude comparator for two unsigned N-bit words.
// Optional macro COMPARADOR_ABORT_EN adds an abort input that cancels a word in RECIBE.
module comparador_serial_der_izq #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          bit_valid,
  input  logic          Ai,
  input  logic          Bi,
`ifdef COMPARADOR_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done,
  output logic [1:0]    resultado,
  output logic [CW-1:0] bit_count
);

  import comparador_defs::*;

  estado_t       r_state;
  estado_t       w_next_state;
  logic [1:0]    r_relation;
  logic [1:0]    r_resultado;
  logic [CW-1:0] r_bit_count;
  logic [1:0]    w_next_relation;
  logic          w_last_pair;
  logic          w_abort;

`ifdef COMPARADOR_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_last_pair = (r_bit_count == CW'(N - 1)) && bit_valid;

  celda_der_izq u_celda (
    .relation      (r_relation),
    .Ai            (Ai),
    .Bi            (Bi),
    .next_relation (w_next_relation)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RECIBE;
      RECIBE: begin
        if (w_abort) begin
          w_next_state = IDLE;
        end else if (w_last_pair) begin
          w_next_state = FIN;
        end
      end
      FIN:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The counter saturates on the last pair so it never wraps inside a word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_relation  <= REL_IGUAL;
      r_resultado <= REL_NONE;
      r_bit_count <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bit_count <= '0;
            r_relation  <= REL_IGUAL;
          end
        end
        RECIBE: begin
          if (w_abort) begin
            r_bit_count <= '0;
          end else if (bit_valid) begin
            r_relation <= w_next_relation;
            if (w_last_pair) begin
              r_resultado <= w_next_relation;
            end else begin
              r_bit_count <= r_bit_count + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state == RECIBE);
  assign done      = (r_state == FIN);
  assign resultado = r_resultado;
  assign bit_count = r_bit_count;

endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// Directed bench for the LSB-first serial comparator with N = 4; expected results
// are queued when a word's last pair is driven and consumed on each done pulse.
module tb_comparador_serial_der_izq;

  localparam int N  = 4;
  localparam int CW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          bit_valid;
  logic          Ai;
  logic          Bi;
  logic          abort;
  logic          busy;
  logic          done;
  logic [1:0]    resultado;
  logic [CW-1:0] bit_count;

  int         numChecks = 0;
  int         numErrors = 0;
  int         doneSeen  = 0;
  int         doneExp   = 0;
  logic [1:0] expQ[$];

  always #5 clk = ~clk;

  comparador_serial_der_izq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_valid (bit_valid),
    .Ai        (Ai),
    .Bi        (Bi),
`ifdef COMPARADOR_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .resultado (resultado),
    .bit_count (bit_count)
  );

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    numChecks++;
    assert (observed === expected) else begin
      numErrors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic a, input logic b);
    bit_valid = 1'b1;
    Ai        = a;
    Bi        = b;
    tick();
    bit_valid = 1'b0;
    Ai        = 1'b0;
    Bi        = 1'b0;
  endtask

  task automatic startWord();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Scoreboard side: every done pulse must match the oldest queued relation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      doneSeen++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 4'(resultado), 4'hf);
      end else begin
        checkOutput("sb_resultado", 4'(resultado), 4'(expQ.pop_front()));
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; Ai = 1'b0; Bi = 1'b0; abort = 1'b0;

    // Reset
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rst_busy", 4'(busy), 4'h0);
    checkOutput("rst_done", 4'(done), 4'h0);
    checkOutput("rst_res",  4'(resultado), 4'h0);
    checkOutput("rst_cnt",  4'(bit_count), 4'h0);

    // bit_valid in IDLE is ignored
    applyStimulus(1'b1, 1'b0);
    checkOutput("idle_busy", 4'(busy), 4'h0);
    checkOutput("idle_cnt",  4'(bit_count), 4'h0);

    // A=1010 B=0110 -> MAYOR
    startWord();
    checkOutput("w1_busy0", 4'(busy), 4'h1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("w1_cnt2", 4'(bit_count), 4'h2);
    applyStimulus(1'b0, 1'b1);
    checkOutput("w1_busy3", 4'(busy), 4'h1);
    checkOutput("w1_res_hold", 4'(resultado), 4'h0);
    expQ.push_back(2'b10); doneExp++;
    applyStimulus(1'b1, 1'b0);
    checkOutput("w1_done", 4'(done), 4'h1);
    checkOutput("w1_fin_busy", 4'(busy), 4'h0);
    checkOutput("w1_res", 4'(resultado), 4'h2);
    tick();
    checkOutput("w1_done_end", 4'(done), 4'h0);
    checkOutput("w1_res_held", 4'(resultado), 4'h2);

    // A=B=0101 with a two-cycle stall between pairs 2 and 3 -> IGUAL
    startWord();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("w2_stall_cnt", 4'(bit_count), 4'h2);
    tick();
    checkOutput("w2_stall_busy", 4'(busy), 4'h1);
    checkOutput("w2_stall_res", 4'(resultado), 4'h2);
    applyStimulus(1'b1, 1'b1);
    expQ.push_back(2'b01); doneExp++;
    applyStimulus(1'b0, 1'b0);
    checkOutput("w2_res", 4'(resultado), 4'h1);
    tick();

    // A=0011 B=1000, start pulsed mid-word -> MENOR
    startWord();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    startWord();
    checkOutput("w3_start_cnt", 4'(bit_count), 4'h2);
    checkOutput("w3_start_busy", 4'(busy), 4'h1);
    applyStimulus(1'b0, 1'b0);
    expQ.push_back(2'b11); doneExp++;
    applyStimulus(1'b0, 1'b1);
    checkOutput("w3_res", 4'(resultado), 4'h3);
    // start during FIN is ignored
    startWord();
    checkOutput("w3_fin_start", 4'(busy), 4'h0);

    // Reset mid-word
    startWord();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("rst_mid_busy", 4'(busy), 4'h0);
    checkOutput("rst_mid_res", 4'(resultado), 4'h0);
    checkOutput("rst_mid_cnt", 4'(bit_count), 4'h0);
    tick();
    checkOutput("rst_mid_done", 4'(done), 4'h0);

`ifdef COMPARADOR_ABORT_EN
    startWord();
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    expQ.push_back(2'b10); doneExp++;
    applyStimulus(1'b1, 1'b0);
    tick();
    startWord();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    abort = 1'b1;
    applyStimulus(1'b1, 1'b1);
    abort = 1'b0;
    checkOutput("abort_busy", 4'(busy), 4'h0);
    checkOutput("abort_done", 4'(done), 4'h0);
    checkOutput("abort_res", 4'(resultado), 4'h2);
    checkOutput("abort_cnt", 4'(bit_count), 4'h0);
    tick();
`endif

    tick();
    checkOutput("done_count", 4'(doneSeen), 4'(doneExp));
    checkOutput("queue_empty", 4'(expQ.size()), 4'h0);

    $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
    $finish;
  end

endmodule
